// File: rtl/product_accumulator.sv
// Accumulates a stream of 32-bit unsigned products into a wide running sum and
// emits the sum, beat count and sticky overflow through a valid/ready output register.
module product_accumulator #(
    parameter int ACC_WIDTH   = 40,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            product,
    input  logic                   in_last,
    input  logic                   acc_clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_overflow
);

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
        return (&c) ? c : c + COUNT_WIDTH'(1);
    endfunction

    logic [ACC_WIDTH-1:0]   acc;
    logic [COUNT_WIDTH-1:0] cnt;
    logic                   ovf;
    logic [ACC_WIDTH:0]     sum;
    logic                   accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // Bit ACC_WIDTH of the widened sum is the carry-out used for the sticky flag.
    assign sum      = {1'b0, acc} + {{(ACC_WIDTH + 1 - 32){1'b0}}, product};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            out_valid    <= 1'b0;
            acc_out      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // Clear wins over a coincident beat, discarding it and any result it would produce.
            if (acc_clear) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (accept) begin
                if (in_last) begin
                    acc_out      <= sum[ACC_WIDTH-1:0];
                    out_count    <= sat_inc(cnt);
                    out_overflow <= ovf | sum[ACC_WIDTH];
                    out_valid    <= 1'b1;
                    acc          <= '0;
                    cnt          <= '0;
                    ovf          <= 1'b0;
                end else begin
                    acc <= sum[ACC_WIDTH-1:0];
                    cnt <= sat_inc(cnt);
                    ovf <= ovf | sum[ACC_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed bench for product_accumulator with a queue scoreboard
// fed by an unbounded-arithmetic reference model.
module tb_product_accumulator;

    localparam int AW = 40;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          acc_clear = 1'b0;
    logic          out_ready = 1'b1;
    logic [31:0]   product = '0;
    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] acc_out;
    logic [CW-1:0] out_count;
    logic          out_overflow;

    always #5 clk = ~clk;

    product_accumulator #(.ACC_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .product(product), .in_last(in_last), .acc_clear(acc_clear),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .out_count(out_count), .out_overflow(out_overflow)
    );

    typedef struct {
        logic [AW-1:0] acc;
        logic [CW-1:0] cnt;
        logic          ovf;
    } res_t;

    res_t    q[$];
    res_t    r_new;
    int      checks = 0;
    int      errors = 0;
    longint  m_sum = 0;
    int      m_n = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs and handshake captured away from the clock edge.
    logic        s_rst = 1'b1, s_valid = 1'b0, s_ready = 1'b0, s_last = 1'b0, s_clear = 1'b0;
    logic [31:0] s_prod = '0;
    always @(negedge clk) begin
        s_rst   = rst;
        s_valid = in_valid;
        s_ready = in_ready;
        s_last  = in_last;
        s_clear = acc_clear;
        s_prod  = product;
    end

    // Reference model: exact sum of the beats in the current group.
    always @(posedge clk) begin
        if (s_rst) begin
            q.delete();
            m_sum = 0;
            m_n   = 0;
        end else if (s_clear) begin
            m_sum = 0;
            m_n   = 0;
        end else if (s_valid && s_ready) begin
            m_sum += longint'(s_prod);
            m_n++;
            if (s_last) begin
                r_new.acc = m_sum[AW-1:0];
                r_new.cnt = (m_n > 255) ? 8'd255 : CW'(m_n);
                r_new.ovf = (m_sum >= (64'd1 << AW));
                q.push_back(r_new);
                m_sum = 0;
                m_n   = 0;
            end
        end
    end

    // Monitor: every presented result is compared until it is consumed.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, (q.size() == 0) || out_ready);
            chk("out_valid", out_valid, q.size() != 0);
            if (out_valid && q.size() != 0) begin
                chk("acc_out", acc_out, q[0].acc);
                chk("out_count", out_count, q[0].cnt);
                chk("out_overflow", out_overflow, q[0].ovf);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] p, input logic l, input logic c);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        in_valid = 1'b1; product = p; in_last = l; acc_clear = c;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else begin
                n++;
                if (n > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout actual=stalled required=accepted");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; acc_clear = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc_out", acc_out, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_overflow", out_overflow, 0);
        chk("rst_in_ready", in_ready, 1);
        idle(1);

        // Basic sum
        send(100, 0, 0); send(200, 0, 0); send(300, 1, 0);
        @(negedge clk);
        chk("basic_valid", out_valid, 1);
        chk("basic_acc", acc_out, 600);
        chk("basic_cnt", out_count, 3);
        chk("basic_ovf", out_overflow, 0);
        @(negedge clk);
        chk("basic_drop", out_valid, 0);
        idle(1);

        // Single-beat maximum
        send(32'hFFFF_FFFF, 1, 0);
        @(negedge clk);
        chk("max_acc", acc_out, 40'h00_FFFF_FFFF);
        chk("max_cnt", out_count, 1);
        idle(2);

        // Backpressure
        out_ready = 1'b0;
        send(100, 0, 0); send(200, 0, 0); send(300, 1, 0);
        in_valid = 1'b1; product = 7; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_acc_hold", acc_out, 600);
            chk("bp_valid_hold", out_valid, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("bp_new_acc", acc_out, 7);
        chk("bp_still_valid", out_valid, 1);
        idle(2);

        // Overflow and saturation
        for (int i = 0; i < 256; i++) send(32'hFFFE_0001, 0, 0);
        send(32'hFFFE_0001, 1, 0);
        @(negedge clk);
        chk("ovf_acc", acc_out, 40'h00_FDFE_0101);
        chk("ovf_flag", out_overflow, 1);
        chk("ovf_cnt", out_count, 255);
        idle(2);

        // Clear
        send(5, 0, 0); send(7, 0, 0);
        acc_clear = 1'b1; idle(1); acc_clear = 1'b0;
        send(9, 1, 0);
        @(negedge clk);
        chk("clr_acc", acc_out, 9);
        chk("clr_cnt", out_count, 1);
        idle(2);
        send(4, 1, 1);
        @(negedge clk);
        chk("clr_coincident", out_valid, 0);
        idle(2);

        // Mid-run reset: pending result dropped, then partial sum dropped
        out_ready = 1'b0;
        send(11, 1, 0);
        @(negedge clk);
        chk("mr_pending", out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1; idle(1); rst = 1'b0;
        @(negedge clk);
        chk("mr_dropped", out_valid, 0);
        out_ready = 1'b1;
        idle(1);
        send(50, 0, 0);
        rst = 1'b1; idle(1); rst = 1'b0;
        send(3, 1, 0);
        @(negedge clk);
        chk("mr_acc", acc_out, 3);
        chk("mr_cnt", out_count, 1);
        idle(2);

        // Randomized traffic
        repeat (1500) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            product   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            in_last   = ($urandom_range(0, 5) == 0);
            acc_clear = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; acc_clear = 1'b0; rst = 1'b0; out_ready = 1'b1;
        idle(4);
        chk("drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
